// File: rtl/imem_loader_if.sv
// Byte-stream ingress and instruction-memory write bus for imem_loader.
// The slave modport is the loader side and the master modport is the environment side.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Streams a big-endian byte image into instruction memory and holds the CPU in reset meanwhile.
// Define IMEM_LOADER_CSUM_EN to add a running XOR checksum output (csum) of all written words.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    imem_loader_if.slave    bus,
    output logic            cpu_rst,
    output logic            load_done,
    output logic [ADDR_W:0] word_count,
    output logic            err_overflow
`ifdef IMEM_LOADER_CSUM_EN
    ,
    output logic [31:0]     csum
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, FINISH, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       asm_q, asm_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              err_overflow_q, err_overflow_d;
    logic              last_q, last_d;
    logic              in_ready_q, in_ready_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              load_done_q, load_done_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    logic        accept;
    logic        load_start;
    logic [4:0]  byte_shift;
    logic [31:0] word_merged;

    assign accept      = bus.in_valid & in_ready_q;
    assign load_start  = start & ((state_q == IDLE) | (state_q == DONE));
    // ~idx equals 3-idx for a 2-bit index, so byte 0 lands in [31:24].
    assign byte_shift  = {~byte_idx_q, 3'b000};
    assign word_merged = asm_q | ({24'b0, bus.in_data} << byte_shift);

    always_comb begin
        state_d        = state_q;
        byte_idx_d     = byte_idx_q;
        asm_d          = asm_q;
        word_count_d   = word_count_q;
        err_overflow_d = err_overflow_q;
        last_d         = last_q;
        im_we_d        = 1'b0;
        im_addr_d      = im_addr_q;
        im_wdata_d     = im_wdata_q;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d         = csum_q;
`endif

        case (state_q)
            LOAD: begin
                if (last_q) begin
                    // The final write strobe has just gone out; leave the stream.
                    state_d = FINISH;
                    last_d  = 1'b0;
                end else if (accept) begin
                    if (word_count_q == DEPTH_C) begin
                        err_overflow_d = 1'b1;
                        byte_idx_d     = byte_idx_q + 2'd1;
                    end else if ((byte_idx_q == 2'd3) || bus.in_last) begin
                        im_we_d      = 1'b1;
                        im_addr_d    = word_count_q[ADDR_W-1:0];
                        im_wdata_d   = word_merged;
                        word_count_d = word_count_q + 1'b1;
                        byte_idx_d   = 2'd0;
                        asm_d        = 32'd0;
`ifdef IMEM_LOADER_CSUM_EN
                        csum_d       = csum_q ^ word_merged;
`endif
                    end else begin
                        asm_d      = word_merged;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                    if (bus.in_last) begin
                        last_d = 1'b1;
                    end
                end
            end
            FINISH:  state_d = DONE;
            default: ;
        endcase

        if (load_start) begin
            state_d        = LOAD;
            byte_idx_d     = 2'd0;
            asm_d          = 32'd0;
            word_count_d   = '0;
            err_overflow_d = 1'b0;
            last_d         = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_d         = 32'd0;
`endif
        end

        in_ready_d  = (state_d == LOAD) & ~last_d;
        cpu_rst_d   = (state_d != DONE);
        load_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            byte_idx_q     <= 2'd0;
            asm_q          <= 32'd0;
            word_count_q   <= '0;
            err_overflow_q <= 1'b0;
            last_q         <= 1'b0;
            in_ready_q     <= 1'b0;
            im_we_q        <= 1'b0;
            im_addr_q      <= '0;
            im_wdata_q     <= 32'd0;
            cpu_rst_q      <= 1'b1;
            load_done_q    <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q         <= 32'd0;
`endif
        end else begin
            state_q        <= state_d;
            byte_idx_q     <= byte_idx_d;
            asm_q          <= asm_d;
            word_count_q   <= word_count_d;
            err_overflow_q <= err_overflow_d;
            last_q         <= last_d;
            in_ready_q     <= in_ready_d;
            im_we_q        <= im_we_d;
            im_addr_q      <= im_addr_d;
            im_wdata_q     <= im_wdata_d;
            cpu_rst_q      <= cpu_rst_d;
            load_done_q    <= load_done_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign load_done    = load_done_q;
    assign word_count   = word_count_q;
    assign err_overflow = err_overflow_q;
`ifdef IMEM_LOADER_CSUM_EN
    assign csum         = csum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as bytes are driven and
// popped by a write monitor; status outputs are checked at fixed cycle offsets.
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            cpu_rst;
    logic            load_done;
    logic [ADDR_W:0] word_count;
    logic            err_overflow;
`ifdef IMEM_LOADER_CSUM_EN
    logic [31:0]     csum;
`endif

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .cpu_rst      (cpu_rst),
        .load_done    (load_done),
        .word_count   (word_count),
        .err_overflow (err_overflow)
`ifdef IMEM_LOADER_CSUM_EN
        ,
        .csum         (csum)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          stalls = 0;
    int          exp_words = 0;
    logic        exp_ovf = 1'b0;
    logic [31:0] exp_csum = 32'd0;
    logic [39:0] exp_q[$];
    logic [7:0]  img[$];

    task automatic check_bits(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [39:0] e;
        if (bus.im_we === 1'b1) begin
            check_bits("write_expected", 40'(exp_q.size() != 0), 40'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_bits("im_addr", 40'(bus.im_addr), 40'(e[39:32]));
                check_bits("im_wdata", 40'(bus.im_wdata), 40'(e[31:0]));
            end
            $display("write addr=%0d data=0x%08h", bus.im_addr, bus.im_wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        int guard = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        stalls += guard;
        if (guard >= 20) check_bits("ready_timeout", 40'(bus.in_ready), 40'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic run_image(input logic with_last);
        logic [31:0] w = 32'd0;
        int idx = 0;
        int cnt = 0;
        for (int i = 0; i < img.size(); i++) begin
            logic last;
            last = with_last && (i == img.size() - 1);
            if (cnt == DEPTH) begin
                exp_ovf = 1'b1;
            end else begin
                w = w | ({24'd0, img[i]} << (8 * (3 - idx)));
                if (idx == 3 || last) begin
                    exp_q.push_back({8'(cnt), w});
                    exp_csum = exp_csum ^ w;
                    cnt++;
                    w = 32'd0;
                    idx = 0;
                end else begin
                    idx++;
                end
            end
            send_byte(img[i], last);
        end
        exp_words = cnt;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_csum = 32'd0;
        exp_ovf = 1'b0;
    endtask

    // Called on the first negedge after the final byte was accepted (the strobe cycle).
    task automatic check_done_seq(input string tag);
        check_bits({tag, "_ready_after_last"}, 40'(bus.in_ready), 40'd0);
        check_bits({tag, "_done_c1"}, 40'(load_done), 40'd0);
        @(negedge clk);
        check_bits({tag, "_done_c2"}, 40'(load_done), 40'd0);
        check_bits({tag, "_cpu_rst_c2"}, 40'(cpu_rst), 40'd1);
        @(negedge clk);
        check_bits({tag, "_done_c3"}, 40'(load_done), 40'd1);
        check_bits({tag, "_cpu_rst_c3"}, 40'(cpu_rst), 40'd0);
        check_bits({tag, "_word_count"}, 40'(word_count), 40'(exp_words));
        check_bits({tag, "_err_overflow"}, 40'(err_overflow), 40'(exp_ovf));
        check_bits({tag, "_sb_empty"}, 40'(exp_q.size()), 40'd0);
`ifdef IMEM_LOADER_CSUM_EN
        check_bits({tag, "_csum"}, 40'(csum), 40'(exp_csum));
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        check_bits({tag, "_cpu_rst"}, 40'(cpu_rst), 40'd1);
        check_bits({tag, "_load_done"}, 40'(load_done), 40'd0);
        check_bits({tag, "_in_ready"}, 40'(bus.in_ready), 40'd0);
        check_bits({tag, "_im_we"}, 40'(bus.im_we), 40'd0);
        check_bits({tag, "_im_addr"}, 40'(bus.im_addr), 40'd0);
        check_bits({tag, "_im_wdata"}, 40'(bus.im_wdata), 40'd0);
        check_bits({tag, "_word_count"}, 40'(word_count), 40'd0);
        check_bits({tag, "_err_overflow"}, 40'(err_overflow), 40'd0);
`ifdef IMEM_LOADER_CSUM_EN
        check_bits({tag, "_csum"}, 40'(csum), 40'd0);
`endif
    endtask

    initial begin
        bus.in_data  = 8'd0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_vals("rst_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("idle");

        // Start coincides with a valid byte in IDLE; that byte must be dropped.
        bus.in_data  = 8'hEE;
        bus.in_valid = 1'b1;
        do_start();
        bus.in_valid = 1'b0;
        check_bits("load_ready", 40'(bus.in_ready), 40'd1);
        check_bits("load_cpu_rst", 40'(cpu_rst), 40'd1);

        img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h29, 8'hFF, 8'hFF};
        run_image(1'b1);
        check_done_seq("full");
`ifdef IMEM_LOADER_CSUM_EN
        check_bits("full_csum_const", 40'(csum), 40'h00_0121FFFA);
`endif

        // Reload from DONE with a partial final word.
        do_start();
        check_bits("reload_cpu_rst", 40'(cpu_rst), 40'd1);
        check_bits("reload_done", 40'(load_done), 40'd0);
        check_bits("reload_word_count", 40'(word_count), 40'd0);
        check_bits("reload_ready", 40'(bus.in_ready), 40'd1);
        img = '{8'h12, 8'h34, 8'hAB};
        run_image(1'b1);
        check_done_seq("partial");

        // Twelve bytes into a two-word memory.
        do_start();
        img.delete();
        for (int i = 1; i <= 12; i++) img.push_back(8'(i * 17));
        stalls = 0;
        run_image(1'b1);
        check_bits("ovf_no_stall", 40'(stalls), 40'd0);
        check_done_seq("ovf");

        // Asynchronous reset partway through a load.
        do_start();
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22};
        run_image(1'b0);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        check_reset_vals("rst_hold_edge");
        rst = 1'b0;
        @(negedge clk);
        check_bits("rst_sb_empty", 40'(exp_q.size()), 40'd0);
        do_start();
        img = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        run_image(1'b1);
        check_done_seq("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
